viterbi_decode: RTL and testbench



---
 rtl/conv_pkg.sv | 32 +++
 rtl/viterbi_acs.sv | 28 ++
 rtl/viterbi_decode.sv | 149 ++++++++++++++
 tb/tb_viterbi_decode.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared (2,1,2) convolutional code constants and trellis helpers
package conv_pkg;

  localparam int K       = 3;
  localparam int NSTATES = 4;

  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;

  typedef logic [1:0] state_t;
  typedef logic [1:0] sym_t;

  // Expected symbol when input bit q leaves state {s1,s2}; bit [1] uses G1, bit [0] uses G0.
  function automatic sym_t conv_sym(input logic q, input state_t state);
    logic [2:0] reg_bits;
    reg_bits = {q, state};
    return {^(reg_bits & G1), ^(reg_bits & G0)};
  endfunction

  // Predecessor of state {q,a} whose oldest bit is sel: {a,sel}.
  function automatic state_t pred(input state_t state, input logic sel);
    return {state[0], sel};
  endfunction

  // Hamming distance between two 2-bit symbols.
  function automatic logic [1:0] hamming2(input sym_t a, input sym_t b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// rtl/viterbi_acs.sv - add-compare-select for one trellis state with saturating sums
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  logic [PM_W:0]   sum0;
  logic [PM_W:0]   sum1;
  logic [PM_W-1:0] sat0;
  logic [PM_W-1:0] sat1;

  // Saturate both candidates first, then pick the smaller; a tie (including both saturated) keeps pred 0.
  always_comb begin
    sum0  = {1'b0, pm0_i} + (PM_W+1)'(bm0_i);
    sum1  = {1'b0, pm1_i} + (PM_W+1)'(bm1_i);
    sat0  = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
    sat1  = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
    dec_o = (sat1 < sat0);
    pm_o  = dec_o ? sat1 : sat0;
  end

endmodule

// File: rtl/viterbi_decode.sv
// rtl/viterbi_decode.sv - hard-decision register-exchange Viterbi decoder; VITERBI_ERR_CNT_EN adds err_cnt
module viterbi_decode
  import conv_pkg::*;
#(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 6
) (
  input  logic        clk_sig,
  input  logic        reset_sig,
  input  logic [1:0]  code_sig,
  input  logic        in_valid,
  input  logic        clr_sig,
  output logic        dec_sig,
  output logic        dec_valid
`ifdef VITERBI_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]   PM_MAX   = {PM_W{1'b1}};
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);
  localparam logic [FILL_W-1:0] FILL_OUT = FILL_W'(TB_DEPTH - 1);
  localparam logic [NSTATES-1:0][PM_W-1:0] PM_RST = {PM_MAX, PM_MAX, PM_MAX, {PM_W{1'b0}}};

  logic [NSTATES-1:0][PM_W-1:0]     pm_q, pm_d, acs_pm, pm_norm;
  logic [NSTATES-1:0]               acs_dec;
  logic [NSTATES-1:0][TB_DEPTH-1:0] surv_q, surv_d, surv_new;
  logic [FILL_W-1:0]                fill_q, fill_d;
  logic                             dec_q, dec_d;
  logic                             dec_valid_q, dec_valid_d;
  logic [PM_W-1:0]                  norm_m;
  state_t                           best;

  for (genvar s = 0; s < NSTATES; s++) begin : g_acs
    localparam state_t ST = state_t'(s);
    logic [1:0] bm0;
    logic [1:0] bm1;

    // Branch metrics on the two edges entering this state; both edges carry input bit ST[1].
    always_comb begin
      bm0 = hamming2(code_sig, conv_sym(ST[1], pred(ST, 1'b0)));
      bm1 = hamming2(code_sig, conv_sym(ST[1], pred(ST, 1'b1)));
    end

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0_i (pm_q[pred(ST, 1'b0)]),
      .pm1_i (pm_q[pred(ST, 1'b1)]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .pm_o  (acs_pm[s]),
      .dec_o (acs_dec[s])
    );
  end

  // Normalize so the best metric is 0 and pick the lowest-index best state.
  always_comb begin
    norm_m = acs_pm[0];
    for (int s = 1; s < NSTATES; s++) begin
      if (acs_pm[s] < norm_m) norm_m = acs_pm[s];
    end
    for (int s = 0; s < NSTATES; s++) begin
      pm_norm[s] = acs_pm[s] - norm_m;
    end
    best = '0;
    for (int s = 1; s < NSTATES; s++) begin
      if (pm_norm[s] < pm_norm[best]) best = state_t'(s);
    end
  end

  // Register exchange: inherit the chosen predecessor's history and append this state's input bit.
  always_comb begin
    for (int s = 0; s < NSTATES; s++) begin
      surv_new[s] = {surv_q[pred(state_t'(s), acs_dec[s])][TB_DEPTH-2:0], 1'(s >> 1)};
    end
  end

  // Next-state selection: clear beats a valid symbol, idle cycles hold everything but dec_valid.
  always_comb begin
    pm_d        = pm_q;
    surv_d      = surv_q;
    fill_d      = fill_q;
    dec_d       = dec_q;
    dec_valid_d = 1'b0;
    if (clr_sig) begin
      pm_d   = PM_RST;
      surv_d = '0;
      fill_d = '0;
      dec_d  = 1'b0;
    end else if (in_valid) begin
      pm_d   = pm_norm;
      surv_d = surv_new;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      if (fill_q >= FILL_OUT) begin
        dec_valid_d = 1'b1;
        dec_d       = surv_new[best][TB_DEPTH-1];
      end
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      pm_q        <= PM_RST;
      surv_q      <= '0;
      fill_q      <= '0;
      dec_q       <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      fill_q      <= fill_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign dec_sig   = dec_q;
  assign dec_valid = dec_valid_q;

`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  // The normalization amount is the number of bits corrected on the best path this step.
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 17'(norm_m);
    err_cnt_d = err_cnt_q;
    if (clr_sig) begin
      err_cnt_d = '0;
    end else if (in_valid) begin
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  // Error counter register.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_decode.sv
// tb/tb_viterbi_decode.sv - self-checking bench for viterbi_decode at PM_W=6 and PM_W=4
module tb_viterbi_decode;

  localparam int TBD = 15;

  logic       clk_sig = 1'b0;
  logic       reset_sig;
  logic [1:0] code_sig;
  logic       in_valid;
  logic       clr_sig;
  logic       dec_sig, dec_valid;
  logic       dec4_sig, dec4_valid;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt, err4_cnt;
`endif

  always #5 clk_sig = ~clk_sig;

  viterbi_decode #(.TB_DEPTH(TBD), .PM_W(6)) dut (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .code_sig  (code_sig),
    .in_valid  (in_valid),
    .clr_sig   (clr_sig),
    .dec_sig   (dec_sig),
    .dec_valid (dec_valid)
`ifdef VITERBI_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  viterbi_decode #(.TB_DEPTH(TBD), .PM_W(4)) dut4 (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .code_sig  (code_sig),
    .in_valid  (in_valid),
    .clr_sig   (clr_sig),
    .dec_sig   (dec4_sig),
    .dec_valid (dec4_valid)
`ifdef VITERBI_ERR_CNT_EN
    ,
    .err_cnt   (err4_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference decoder state, index 0 = PM_W 6, index 1 = PM_W 4
  int maxv[2] = '{63, 15};
  int pm_m[2][4];
  bit hist[2][4][512];
  int len_m[2];
  int err_m[2];
  bit exp_dv[2];
  bit exp_dec[2];

  bit info[21];
  bit exp_bits[7] = '{1, 0, 1, 1, 0, 0, 0};
  int e1, e2;
  bit dq[$];
  int nsym;
  int first_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) pm_m[k][s] = (s == 0) ? 0 : maxv[k];
      len_m[k] = 0;
      err_m[k] = 0;
      exp_dv[k] = 0;
      exp_dec[k] = 0;
    end
    dq.delete();
    nsym = 0;
    first_at = -1;
    e1 = 0;
    e2 = 0;
  endtask

  // Forward trellis walk over every (old state, input bit) edge; the even predecessor is seen first.
  task automatic model_step(input int k, input int code);
    int npm[4];
    bit nh[4][512];
    int m, best, cand;
    for (int s = 0; s < 4; s++) npm[s] = -1;
    for (int p = 0; p < 4; p++) begin
      for (int q = 0; q < 2; q++) begin
        int s1 = p >> 1;
        int s2 = p & 1;
        int ns = q * 2 + s1;
        int sym = ((q ^ s1 ^ s2) << 1) | (q ^ s2);
        int diff = sym ^ code;
        cand = pm_m[k][p] + (diff & 1) + ((diff >> 1) & 1);
        if (cand > maxv[k]) cand = maxv[k];
        if (npm[ns] < 0 || cand < npm[ns]) begin
          npm[ns] = cand;
          for (int j = 0; j < len_m[k]; j++) nh[ns][j] = hist[k][p][j];
          nh[ns][len_m[k]] = bit'(q);
        end
      end
    end
    m = npm[0];
    for (int s = 1; s < 4; s++) if (npm[s] < m) m = npm[s];
    best = 0;
    for (int s = 0; s < 4; s++) begin
      pm_m[k][s] = npm[s] - m;
      if (pm_m[k][s] < pm_m[k][best]) best = s;
    end
    err_m[k] = (err_m[k] + m > 65535) ? 65535 : err_m[k] + m;
    len_m[k]++;
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < len_m[k]; j++) hist[k][s][j] = nh[s][j];
    exp_dv[k] = (len_m[k] >= TBD);
    if (exp_dv[k]) exp_dec[k] = hist[k][best][len_m[k] - TBD];
  endtask

  task automatic compare_all();
    chk("dv6", dec_valid, exp_dv[0]);
    chk("dv4", dec4_valid, exp_dv[1]);
    if (exp_dv[0]) chk("dec6", dec_sig, exp_dec[0]);
    if (exp_dv[1]) chk("dec4", dec4_sig, exp_dec[1]);
    for (int i = 0; i < 4; i++) begin
      chk("pm6", dut.pm_q[i], pm_m[0][i]);
      chk("pm4", dut4.pm_q[i], pm_m[1][i]);
    end
`ifdef VITERBI_ERR_CNT_EN
    chk("err6", err_cnt, err_m[0]);
    chk("err4", err4_cnt, err_m[1]);
`endif
  endtask

  task automatic step(input logic [1:0] code, input bit valid, input bit clr);
    code_sig = code;
    in_valid = valid;
    clr_sig  = clr;
    @(posedge clk_sig);
    if (clr) begin
      model_reset();
    end else if (valid) begin
      model_step(0, int'(code));
      model_step(1, int'(code));
      nsym++;
    end else begin
      exp_dv[0] = 0;
      exp_dv[1] = 0;
    end
    #1;
    compare_all();
    if (dec_valid === 1'b1) begin
      dq.push_back(dec_sig);
      if (first_at < 0) first_at = nsym;
    end
  endtask

  task automatic enc(input bit q, output logic [1:0] sym);
    sym = {1'(q ^ e1[0] ^ e2[0]), 1'(q ^ e2[0])};
    e2 = e1;
    e1 = int'(q);
  endtask

  task automatic play(input int n, input bit gapped, input bit flip3);
    logic [1:0] sym;
    for (int i = 0; i < n; i++) begin
      enc(info[i], sym);
      if (flip3 && i == 2) sym ^= 2'b01;
      step(sym, 1, 0);
      if (gapped) step(2'($urandom), 0, 0);
    end
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, dq.size(), 7);
    for (int i = 0; i < 7; i++) if (i < dq.size()) chk({tag, "_bit"}, dq[i], exp_bits[i]);
    chk({tag, "_first"}, first_at, TBD);
  endtask

  initial begin
    logic [1:0] sym;
    int acc, mn, orv;
    for (int i = 0; i < 21; i++) info[i] = 0;
    info[0] = 1; info[2] = 1; info[3] = 1;
    reset_sig = 0; code_sig = 0; in_valid = 0; clr_sig = 0;
    model_reset();
    repeat (2) @(posedge clk_sig);
    #1;
    compare_all();
    chk("rst_dec", dec_sig, 0);
    chk("rst_fill", dut.fill_q, 0);
    #3 reset_sig = 1;

    // 1: clean stream
    play(21, 0, 0);
    check_seq("clean");
`ifdef VITERBI_ERR_CNT_EN
    chk("clean_err", err_cnt, 0);
`endif

    // clear mid-stream while outputs are active; the clear-cycle symbol is dropped
    step(2'b00, 1, 1);
    play(17, 0, 0);
    step(2'b11, 1, 1);
    chk("clr_dv", dec_valid, 0);
    chk("clr_fill", dut.fill_q, 0);

    // 2: single symbol error
    play(21, 0, 1);
    check_seq("flip");
`ifdef VITERBI_ERR_CNT_EN
    chk("flip_err", err_cnt, 1);
`endif

    // 3: all-zero stream
    step(2'b00, 1, 1);
    for (int i = 0; i < 40; i++) step(2'b00, 1, 0);
    chk("zero_pulses", dq.size(), 26);
    orv = 0;
    foreach (dq[i]) orv |= int'(dq[i]);
    chk("zero_bits", orv, 0);

    // 4: gapped input
    step(2'b00, 1, 1);
    play(21, 1, 0);
    check_seq("gap");

    // 5: asynchronous reset mid-stream then replay
    step(2'b00, 1, 1);
    play(8, 0, 0);
    #2 reset_sig = 0;
    #1;
    model_reset();
    chk("arst_dv", dec_valid, 0);
    chk("arst_dec", dec_sig, 0);
    chk("arst_fill", dut.fill_q, 0);
    for (int i = 0; i < 4; i++) chk("arst_pm4", dut4.pm_q[i], pm_m[1][i]);
    #2 reset_sig = 1;
    play(21, 0, 0);
    check_seq("replay");

    // 6: random noisy stream, PM_W=4 saturation and normalization
    step(2'b00, 1, 1);
    acc = 0;
    while (acc < 200) begin
      if ($urandom_range(3) != 0) begin
        enc(bit'($urandom_range(1)), sym);
        if (acc >= 100) sym = 2'($urandom);
        else if ($urandom_range(3) == 0) sym ^= 2'($urandom);
        step(sym, 1, 0);
        mn = 99;
        for (int i = 0; i < 4; i++) if (int'(dut4.pm_q[i]) < mn) mn = int'(dut4.pm_q[i]);
        chk("min_pm4", mn, 0);
        acc++;
      end else begin
        step(2'($urandom), 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
